// File: rtl/y_gather_reg_if.sv
`default_nettype none
// ============================================================================
// y_gather_reg_if : capture/readback bus of the y_gather_reg output collector
// Rev 1.0
// ============================================================================
interface y_gather_reg_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 5
);
    logic              EN;
    logic              CLEAR;
    logic              CAPTURE;
    logic [DATA_W-1:0] DIN;
    logic              RD_EN;
    logic [IDX_W-1:0]  IDX;
    logic [DATA_W-1:0] DOUT;
    logic              DOUT_VALID;
    logic [IDX_W:0]    COUNT;
    logic              FULL;
    logic              OVERFLOW;

    modport master (
        output EN, CLEAR, CAPTURE, DIN, RD_EN, IDX,
        input  DOUT, DOUT_VALID, COUNT, FULL, OVERFLOW
    );

    modport slave (
        input  EN, CLEAR, CAPTURE, DIN, RD_EN, IDX,
        output DOUT, DOUT_VALID, COUNT, FULL, OVERFLOW
    );
endinterface
`default_nettype wire

// File: rtl/y_gather_reg.sv
`default_nettype none
// ============================================================================
// y_gather_reg : tail-first shift collector with indexed registered readback.
// Optional macro Y_GATHER_RELU_EN applies ReLU to DIN at capture.
// Rev 1.0
// ============================================================================
module y_gather_reg #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5
) (
    input  wire           CLK,
    input  wire           RST,
    y_gather_reg_if.slave bus
);
    localparam logic [1:0]     c_ST_EMPTY   = 2'd0;
    localparam logic [1:0]     c_ST_FILLING = 2'd1;
    localparam logic [1:0]     c_ST_FULL    = 2'd2;
    localparam logic [IDX_W:0] c_LAST_CNT   = (IDX_W+1)'(DEPTH - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [IDX_W:0]    r_count;
    logic              r_ovf;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic [DATA_W-1:0] r_pipe [DEPTH];

    logic              w_clear;
    logic              w_cap_req;
    logic              w_full;
    logic              w_cap_ok;
    logic              w_cap_ovf;
    logic [DATA_W-1:0] w_din_cap;

    assign w_clear   = bus.EN & bus.CLEAR;
    assign w_cap_req = bus.EN & bus.CAPTURE & ~bus.CLEAR;

`ifdef Y_GATHER_RELU_EN
    assign w_din_cap = bus.DIN[DATA_W-1] ? '0 : bus.DIN;
`else
    assign w_din_cap = bus.DIN;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_clear) begin
            w_state_nxt = c_ST_EMPTY;
        end else begin
            case (r_state)
                c_ST_EMPTY, c_ST_FILLING: begin
                    if (w_cap_ok) begin
                        w_state_nxt = (r_count == c_LAST_CNT) ? c_ST_FULL : c_ST_FILLING;
                    end
                end
                c_ST_FULL: w_state_nxt = c_ST_FULL;
                default:   w_state_nxt = c_ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_full    = (r_state == c_ST_FULL);
        w_cap_ok  = w_cap_req & ~w_full;
        w_cap_ovf = w_cap_req & w_full;
    end

    // Read samples the chain before any shift in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (bus.EN) begin
            if (w_clear) begin
                r_count      <= '0;
                r_ovf        <= 1'b0;
                r_dout_valid <= 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_pipe[i] <= '0;
                end
            end else begin
                if (bus.RD_EN) begin
                    r_dout       <= r_pipe[bus.IDX];
                    r_dout_valid <= 1'b1;
                end else begin
                    r_dout_valid <= 1'b0;
                end
                if (w_cap_ok) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        r_pipe[i] <= r_pipe[i+1];
                    end
                    r_pipe[DEPTH-1] <= w_din_cap;
                    r_count         <= r_count + 1'b1;
                end
                if (w_cap_ovf) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign bus.DOUT       = r_dout;
    assign bus.DOUT_VALID = r_dout_valid;
    assign bus.COUNT      = r_count;
    assign bus.FULL       = w_full;
    assign bus.OVERFLOW   = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_y_gather_reg.sv
`default_nettype none
// ============================================================================
// tb_y_gather_reg : vector table plus scoreboarded readback for y_gather_reg
// Rev 1.0
// ============================================================================
module tb_y_gather_reg;
    typedef struct {
        logic        en;
        logic        clear;
        logic        cap;
        logic [15:0] din;
        logic        rd;
        logic [4:0]  idx;
        logic [15:0] exp_dout;
        logic [5:0]  exp_count;
        logic        exp_ovf;
    } vec_t;

    logic CLK;
    logic RST;
    int   n_cmp;
    int   n_bad;
    logic exp_valid;
    logic [15:0] sb_q [$];
    vec_t vt [12];

    y_gather_reg_if #(.DATA_W(16), .IDX_W(5)) bus ();

    y_gather_reg #(.DATA_W(16), .DEPTH(32), .IDX_W(5)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input logic en, input logic clear, input logic cap,
                         input logic [15:0] din, input logic rd, input logic [4:0] idx,
                         input logic [15:0] exp_dout, input logic [5:0] exp_count,
                         input logic exp_ovf);
        logic [15:0] want;
        bus.EN = en; bus.CLEAR = clear; bus.CAPTURE = cap;
        bus.DIN = din; bus.RD_EN = rd; bus.IDX = idx;
        if (en && rd && !clear) sb_q.push_back(exp_dout);
        @(posedge CLK); #1;
        if (en) exp_valid = rd && !clear;
        chk("count", 32'(bus.COUNT), 32'(exp_count));
        chk("full", 32'(bus.FULL), 32'(exp_count == 6'd32));
        chk("overflow", 32'(bus.OVERFLOW), 32'(exp_ovf));
        chk("dout_valid", 32'(bus.DOUT_VALID), 32'(exp_valid));
        if (en && rd && !clear) begin
            if (sb_q.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                want = sb_q.pop_front();
                chk($sformatf("dout[idx=%0d]", idx), 32'(bus.DOUT), 32'(want));
            end
        end
    endtask

    initial begin
        // en clr cap din      rd idx  exp_dout cnt ovf
        vt[0]  = '{1, 0, 1, 16'h000A, 0, 5'd0,  16'h0000, 6'd1, 0};
        vt[1]  = '{1, 0, 1, 16'h000B, 0, 5'd0,  16'h0000, 6'd2, 0};
        vt[2]  = '{1, 0, 1, 16'h000C, 0, 5'd0,  16'h0000, 6'd3, 0};
        vt[3]  = '{1, 0, 0, 16'h0000, 1, 5'd29, 16'h000A, 6'd3, 0};
        vt[4]  = '{1, 0, 0, 16'h0000, 1, 5'd30, 16'h000B, 6'd3, 0};
        vt[5]  = '{1, 0, 0, 16'h0000, 1, 5'd31, 16'h000C, 6'd3, 0};
        vt[6]  = '{1, 0, 0, 16'h0000, 1, 5'd0,  16'h0000, 6'd3, 0};
        vt[7]  = '{1, 0, 1, 16'h000D, 1, 5'd31, 16'h000C, 6'd4, 0};
        vt[8]  = '{1, 0, 0, 16'h0000, 1, 5'd28, 16'h000A, 6'd4, 0};
        vt[9]  = '{0, 0, 1, 16'h00EE, 1, 5'd0,  16'h0000, 6'd4, 0};
        vt[10] = '{1, 1, 1, 16'h00EE, 1, 5'd31, 16'h0000, 6'd0, 0};
        vt[11] = '{1, 0, 0, 16'h0000, 1, 5'd31, 16'h0000, 6'd0, 0};

        n_cmp = 0; n_bad = 0; exp_valid = 1'b0;
        RST = 1'b1;
        bus.EN = 1'b0; bus.CLEAR = 1'b0; bus.CAPTURE = 1'b0;
        bus.DIN = '0; bus.RD_EN = 1'b0; bus.IDX = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_count", 32'(bus.COUNT), 32'd0);
        chk("rst_full", 32'(bus.FULL), 32'd0);
        chk("rst_ovf", 32'(bus.OVERFLOW), 32'd0);
        chk("rst_valid", 32'(bus.DOUT_VALID), 32'd0);
        chk("rst_dout", 32'(bus.DOUT), 32'd0);
        RST = 1'b0;

        for (int i = 0; i < 12; i++) begin
            apply(vt[i].en, vt[i].clear, vt[i].cap, vt[i].din, vt[i].rd, vt[i].idx,
                  vt[i].exp_dout, vt[i].exp_count, vt[i].exp_ovf);
        end

        // Fill with 1..32, then indexed reads.
        for (int k = 1; k <= 32; k++) begin
            apply(1, 0, 1, 16'(k), 0, 5'd0, 16'h0, 6'(k), 0);
        end
        apply(1, 0, 0, 16'h0, 1, 5'd0,  16'd1,  6'd32, 0);
        apply(1, 0, 0, 16'h0, 1, 5'd31, 16'd32, 6'd32, 0);
        apply(1, 0, 0, 16'h0, 1, 5'd15, 16'd16, 6'd32, 0);

        // Capture while full sets sticky overflow; clear wipes everything.
        apply(1, 0, 1, 16'hFFFF, 0, 5'd0,  16'h0,  6'd32, 1);
        apply(1, 0, 1, 16'hFFFF, 1, 5'd31, 16'd32, 6'd32, 1);
        apply(1, 0, 0, 16'h0,    0, 5'd0,  16'h0,  6'd32, 1);
        apply(1, 1, 0, 16'h0,    0, 5'd0,  16'h0,  6'd0,  0);
        for (int i = 0; i < 32; i++) begin
            apply(1, 0, 0, 16'h0, 1, 5'(i), 16'h0, 6'd0, 0);
        end

        // Same-cycle read and capture returns the pre-shift tail.
        apply(1, 0, 1, 16'h0044, 0, 5'd0,  16'h0,    6'd1, 0);
        apply(1, 0, 1, 16'h0055, 1, 5'd31, 16'h0044, 6'd2, 0);
        apply(1, 0, 0, 16'h0,    1, 5'd31, 16'h0055, 6'd2, 0);
        apply(1, 0, 0, 16'h0,    1, 5'd30, 16'h0044, 6'd2, 0);

        // EN low freezes all state, including DOUT_VALID and DOUT.
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 1, 16'h0099, 1, 5'd0, 16'h0, 6'd2, 0);
        end
        chk("dout_hold_en_low", 32'(bus.DOUT), 32'h0044);
        apply(1, 0, 0, 16'h0, 1, 5'd31, 16'h0055, 6'd2, 0);
        apply(1, 0, 0, 16'h0, 1, 5'd29, 16'h0000, 6'd2, 0);

        // Asynchronous reset mid-fill.
        apply(1, 1, 0, 16'h0, 0, 5'd0, 16'h0, 6'd0, 0);
        for (int k = 1; k <= 10; k++) begin
            apply(1, 0, 1, 16'(16'h0100 + k), 0, 5'd0, 16'h0, 6'(k), 0);
        end
        apply(1, 0, 0, 16'h0, 1, 5'd31, 16'h010A, 6'd10, 0);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_count", 32'(bus.COUNT), 32'd0);
        chk("async_rst_full", 32'(bus.FULL), 32'd0);
        chk("async_rst_ovf", 32'(bus.OVERFLOW), 32'd0);
        chk("async_rst_valid", 32'(bus.DOUT_VALID), 32'd0);
        chk("async_rst_dout", 32'(bus.DOUT), 32'd0);
        exp_valid = 1'b0;
        #2 RST = 1'b0;
        apply(1, 0, 1, 16'h0077, 0, 5'd0,  16'h0,    6'd1, 0);
        apply(1, 0, 0, 16'h0,    1, 5'd31, 16'h0077, 6'd1, 0);
        apply(1, 0, 0, 16'h0,    1, 5'd30, 16'h0000, 6'd1, 0);

        // Negative sample handling at capture.
        apply(1, 0, 1, 16'h8001, 0, 5'd0, 16'h0, 6'd2, 0);
        apply(1, 0, 1, 16'h0005, 0, 5'd0, 16'h0, 6'd3, 0);
`ifdef Y_GATHER_RELU_EN
        apply(1, 0, 0, 16'h0, 1, 5'd30, 16'h0000, 6'd3, 0);
`else
        apply(1, 0, 0, 16'h0, 1, 5'd30, 16'h8001, 6'd3, 0);
`endif
        apply(1, 0, 0, 16'h0, 1, 5'd31, 16'h0005, 6'd3, 0);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
